// File: rtl/iter_mul_unit_pkg.sv
// Shared types and constants for the iterative multiplier and its helpers.
package mul_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 32;

  // Bit counter must be able to hold WIDTH after the final increment.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/iter_mul_unit_if.sv
// Request/response bundle between the EXECUTE stage and the multiplier.
interface iter_mul_unit_if #(
  parameter int unsigned WIDTH = mul_pkg::DEFAULT_WIDTH
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             flush;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             overflow;

  modport master (
    output start, signed_op, op_a, op_b, flush,
    input  ready, busy, done, result_lo, result_hi, overflow
  );

  modport slave (
    input  start, signed_op, op_a, op_b, flush,
    output ready, busy, done, result_lo, result_hi, overflow
  );
endinterface

// File: rtl/iter_mul_unit_signfix.sv
// Sign handling around an unsigned core: operand magnitudes and final negate.
module mul_signfix
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               signed_op_i,
  input  logic [WIDTH-1:0]   op_a_i,
  input  logic [WIDTH-1:0]   op_b_i,
  output logic [WIDTH-1:0]   mag_a_o,
  output logic [WIDTH-1:0]   mag_b_o,
  output logic               neg_o,
  input  logic               neg_i,
  input  logic [2*WIDTH-1:0] prod_i,
  output logic [2*WIDTH-1:0] prod_o
);

  logic neg_a;
  logic neg_b;

  // Magnitudes wrap naturally: the most negative value maps to 2^(WIDTH-1).
  always_comb begin
    neg_a   = signed_op_i & op_a_i[WIDTH-1];
    neg_b   = signed_op_i & op_b_i[WIDTH-1];
    mag_a_o = neg_a ? (-op_a_i) : op_a_i;
    mag_b_o = neg_b ? (-op_b_i) : op_b_i;
    neg_o   = neg_a ^ neg_b;
    prod_o  = neg_i ? (-prod_i) : prod_i;
  end

endmodule

// File: rtl/iter_mul_unit.sv
// Multi-cycle shift-add multiplier, one multiplier bit per cycle.
module iter_mul_unit
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH      = DEFAULT_WIDTH,
  parameter int unsigned EARLY_EXIT = 1
) (
  input  logic            clock,
  input  logic            reset,
  iter_mul_unit_if.slave  bus
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               sgn_q, sgn_d;
  logic [WIDTH-1:0]   res_lo_q, res_lo_d;
  logic [WIDTH-1:0]   res_hi_q, res_hi_d;
  logic               ovf_q, ovf_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               neg_in;
  logic [2*WIDTH-1:0] addend, acc_sum, prod;
  logic [WIDTH-1:0]   mplier_shr;
  logic               finish;

  // Product is taken from this edge's accumulation so the exit edge needs no extra cycle.
  assign addend     = mplier_q[0] ? ({{WIDTH{1'b0}}, mcand_q} << cnt_q) : '0;
  assign acc_sum    = acc_q + addend;
  assign mplier_shr = mplier_q >> 1;
  assign finish     = (cnt_q == CW'(WIDTH - 1)) ||
                      ((EARLY_EXIT != 0) && (mplier_shr == '0));

  mul_signfix #(.WIDTH(WIDTH)) u_signfix (
    .signed_op_i (bus.signed_op),
    .op_a_i      (bus.op_a),
    .op_b_i      (bus.op_b),
    .mag_a_o     (mag_a),
    .mag_b_o     (mag_b),
    .neg_o       (neg_in),
    .neg_i       (neg_q),
    .prod_i      (acc_sum),
    .prod_o      (prod)
  );

  // State and datapath registers; reset clears everything.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      sgn_q    <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      sgn_q    <= sgn_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state logic: capture on accepted start, iterate in RUN, load result on exit.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    sgn_d    = sgn_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start && !bus.flush) begin
          state_d  = S_RUN;
          mcand_d  = mag_a;
          mplier_d = mag_b;
          neg_d    = neg_in;
          sgn_d    = bus.signed_op;
          acc_d    = '0;
          cnt_d    = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d    = acc_sum;
          mplier_d = mplier_shr;
          cnt_d    = cnt_q + CW'(1);
          if (finish) begin
            state_d  = S_DONE;
            res_hi_d = prod[2*WIDTH-1:WIDTH];
            res_lo_d = prod[WIDTH-1:0];
            ovf_d    = sgn_q ? (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}})
                             : (prod[2*WIDTH-1:WIDTH] != '0);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.ready     = (state_q == S_IDLE) || (state_q == S_DONE);
  assign bus.busy      = (state_q == S_RUN);
  assign bus.done      = (state_q == S_DONE);
  assign bus.result_lo = res_lo_q;
  assign bus.result_hi = res_hi_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: doc/iter_mul_unit.md
Name: iter_mul_unit

Overview:
- Parametrised, multi-cycle shift-add integer multiplier that generalises the MIPS MUL path.
- Sits beside the ALU in the EXECUTE stage. The pipeline starts an operation and stalls on `busy`, then consumes a full 2*WIDTH product plus an overflow flag.
- Adds signed/unsigned mode, optional early termination, and a pipeline-flush abort.

Parameters:
- WIDTH, 32: operand width in bits; must be ≥ 4.
- EARLY_EXIT, 1: 1 = finish as soon as the remaining multiplier bits are all zero; 0 = fixed latency.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  request a multiply; accepted only when `ready`=1.
- signed_op  in  1  1 = two's-complement operands, 0 = unsigned; sampled with `start`.
- op_a  in  WIDTH  multiplicand; sampled with `start`.
- op_b  in  WIDTH  multiplier; sampled with `start`.
- flush  in  1  abort any operation in flight.
- ready  out  1  unit can accept `start` (state IDLE or DONE).
- busy  out  1  operation in progress (state RUN).
- done  out  1  one-cycle pulse; results valid.
- result_lo  out  WIDTH  low half of the product.
- result_hi  out  WIDTH  high half of the product.
- overflow  out  1  product does not fit in WIDTH bits.

Behaviour:
- Reset (reset=0 at an edge, any state including mid-RUN):
  - State returns to IDLE; all internal registers cleared.
  - Outputs: ready=1, busy=0, done=0, result_lo=0, result_hi=0, overflow=0.
- States:
  - IDLE: waits for start.
  - RUN: one multiplier bit processed per cycle.
  - DONE: results held, done=1 for exactly one cycle.
- Transitions:
  - IDLE/DONE → RUN on start=1 (and flush=0).
  - DONE → IDLE when start=0.
  - RUN → DONE after the last bit, or earlier under early exit.
  - RUN → IDLE on flush.
- Operand capture (edge k, start accepted):
  - Signed mode: latch |op_a| and |op_b| as WIDTH-bit unsigned magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1). Latch neg = sign(op_a) XOR sign(op_b).
  - Unsigned mode: latch operands unchanged; neg=0.
  - Clear the 2*WIDTH accumulator and the bit counter.
- RUN, each edge:
  - If multiplier LSB=1, accumulator += multiplicand << counter.
  - Multiplier shifts right by 1; counter increments.
- RUN exit:
  - Fixed latency: the edge that processes bit WIDTH-1, i.e. edge k+WIDTH.
  - EARLY_EXIT=1: also exit at the first RUN edge where the shifted multiplier is zero.
- Result load (same edge that enters DONE):
  - P = neg ? -acc : acc, computed over 2*WIDTH bits.
  - result_hi = P[2W-1:W]; result_lo = P[W-1:0].
- Overflow:
  - Unsigned: result_hi ≠ 0.
  - Signed: result_hi ≠ {WIDTH{result_lo[WIDTH-1]}}.
- Output timing and holding:
  - done=1 only in the cycle after DONE is entered.
  - result_* and overflow hold their values until the next accepted start's result load, or until reset.
- Latency (start edge to done visible):
  - WIDTH cycles when fixed.
  - EARLY_EXIT: 1 + index of the highest set bit of |op_b|; 1 when op_b=0.
- Ignored or overridden requests:
  - start during RUN is ignored (ready=0); no queueing.
  - start in DONE is accepted: back-to-back operation, done deasserts next cycle.
  - flush during RUN goes to IDLE; outputs keep their previous values; no done pulse.
  - flush and start together: flush wins, start is not accepted.
  - reset overrides everything.

Decomposition:
- Shared package mul_pkg:
  - State enum (IDLE, RUN, DONE).
  - Default WIDTH constant.
  - Counter width = $clog2(WIDTH)+1.
- Sub-module mul_signfix (combinational):
  - Operand magnitude/sign extraction.
  - Final 2*WIDTH conditional negate.
  - Reused by a future DIV unit.

Test Plan (WIDTH=32):
- Unsigned 5×7, EARLY_EXIT=0 → done exactly 32 cycles after start edge; lo=35, hi=0, overflow=0.
- Signed -3×4 → lo=0xFFFFFFF4, hi=0xFFFFFFFF, overflow=0. Signed 0x80000000×0x80000000 → hi=0x40000000, lo=0, overflow=1.
- Unsigned 0x00010000×0x00010000 → hi=1, lo=0, overflow=1. EARLY_EXIT=1 with op_b=1 → done 1 cycle after start; op_b=0 → lo=hi=0, latency 1.
- Factorial chain 1×2×…×7, each next start issued in the DONE cycle → final lo=5040; busy never overlaps done; start pulses during RUN are ignored with no result change.
- flush at RUN cycle 10 → IDLE next edge, no done pulse, prior results unchanged. flush and start in the same cycle → not accepted.
- reset=0 at RUN cycle 5 → next edge: ready=1, busy=0, done=0, results and overflow = 0. New start afterwards completes correctly.
